// File: rtl/hb_round_ctrl.sv
// hb_round_ctrl: Feistel round sequencer; nibble-split state, req/ack round function, owns round counter.
module hb_round_ctrl #(
  parameter int ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic [0:63] i_blk_in,
  output logic        o_ready,
  output logic        o_busy,
  output logic [0:7]  o_rnd,
  output logic        o_f_req,
  output logic [0:31] o_f_data,
  input  logic        i_f_ack,
  input  logic [0:31] i_f_out,
  output logic        o_done,
  output logic [0:63] o_blk_out
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t r_state, w_next;
  logic [0:63] r_s, r_blk, w_s_upd;
  logic [0:7]  r_rnd;
  logic [0:31] w_h, w_lo, w_x;
  logic        w_odd, w_last, w_ack;
  assign w_odd  = r_rnd[7];
  assign w_last = r_rnd == 8'(ROUNDS - 1);
  assign w_ack  = r_state == REQ && i_f_ack;
  assign w_x    = (w_odd ? w_lo : w_h) ^ i_f_out;
  genvar n;
  generate
    for (n = 0; n < 8; n++) begin : g_n
      assign w_h[4*n +: 4]          = r_s[8*n +: 4];
      assign w_lo[4*n +: 4]         = r_s[8*n+4 +: 4];
      assign w_s_upd[8*n +: 4]      = w_odd ? w_h[4*n +: 4] : w_x[4*n +: 4];
      assign w_s_upd[8*n+4 +: 4]    = w_odd ? w_x[4*n +: 4] : w_lo[4*n +: 4];
    end
  endgenerate
  always_comb begin
    w_next = r_state;
    if (i_abort) w_next = IDLE;
    else if (r_state == IDLE) w_next = i_start ? REQ : IDLE;
    else if (r_state == REQ) w_next = (i_f_ack && w_last) ? DONE : REQ;
    else w_next = IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_s     <= '0;
      r_blk   <= '0;
      r_rnd   <= '0;
    end else begin
      r_state <= w_next;
      if (i_abort || r_state == DONE) r_rnd <= '0;
      else if (r_state == IDLE && i_start) begin
        r_s   <= i_blk_in;
        r_rnd <= '0;
      end else if (w_ack) begin
        r_s <= w_s_upd;
        if (w_last) r_blk <= w_s_upd;
        else r_rnd <= r_rnd + 8'd1;
      end
    end
  end
  assign o_ready   = r_state == IDLE;
  assign o_busy    = r_state == REQ;
  assign o_f_req   = r_state == REQ;
  assign o_done    = r_state == DONE;
  assign o_rnd     = r_rnd;
  assign o_f_data  = w_odd ? w_h : w_lo;
  assign o_blk_out = r_blk;
endmodule

// File: tb/tb_hb_round_ctrl.sv
// tb_hb_round_ctrl: directed checks of hb_round_ctrl at ROUNDS=16, 1 and 2 driven by shared stimulus.
module tb_hb_round_ctrl;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, f_ack = 0;
  logic [0:63] blk_in = 64'h0123456789ABCDEF;
  logic [0:31] f_out = '0;
  logic        rdy16, bsy16, req16, dn16, rdy1, bsy1, req1, dn1, rdy2, bsy2, req2, dn2;
  logic [0:7]  rnd16, rnd1, rnd2;
  logic [0:31] fd16, fd1, fd2;
  logic [0:63] bo16, bo1, bo2;
  int n_vec = 0, n_err = 0;
  always #5 clk = ~clk;
  hb_round_ctrl #(.ROUNDS(16)) d16 (.clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_blk_in(blk_in), .o_ready(rdy16), .o_busy(bsy16), .o_rnd(rnd16), .o_f_req(req16),
    .o_f_data(fd16), .i_f_ack(f_ack), .i_f_out(f_out), .o_done(dn16), .o_blk_out(bo16));
  hb_round_ctrl #(.ROUNDS(1)) d1 (.clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_blk_in(blk_in), .o_ready(rdy1), .o_busy(bsy1), .o_rnd(rnd1), .o_f_req(req1),
    .o_f_data(fd1), .i_f_ack(f_ack), .i_f_out(f_out), .o_done(dn1), .o_blk_out(bo1));
  hb_round_ctrl #(.ROUNDS(2)) d2 (.clk(clk), .rst_n(rst_n), .i_start(start), .i_abort(abort),
    .i_blk_in(blk_in), .o_ready(rdy2), .o_busy(bsy2), .o_rnd(rnd2), .o_f_req(req2),
    .o_f_data(fd2), .i_f_ack(f_ack), .i_f_out(f_out), .o_done(dn2), .o_blk_out(bo2));
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic chk_idle(input string tag, input logic [63:0] exp_blk, input logic [31:0] exp_fd);
    chk({tag, "_ctl"}, {60'd0, rdy16, bsy16, req16, dn16}, 64'h8);
    chk({tag, "_rnd"}, rnd16, 0);
    chk({tag, "_fdata"}, fd16, exp_fd);
    chk({tag, "_blk"}, bo16, exp_blk);
  endtask
  initial begin
    #2;
    chk_idle("reset", 64'h0, 32'h0);
    tick(2);
    rst_n = 1;
    tick();
    // identity round function, zero-wait acks
    f_ack = 1;
    start = 1;
    tick();
    start = 0;
    chk("split_r0", fd16, 32'h13579BDF);
    for (int k = 0; k < 16; k++) begin
      chk("id_rnd", rnd16, k);
      chk("id_busy", {62'd0, req16, dn16}, 64'h2);
      if (k == 1) chk("split_r1", fd16, 32'h02468ACE);
      tick();
    end
    chk("id_done", dn16, 1);
    chk("id_blk", bo16, 64'h0123456789ABCDEF);
    tick();
    chk_idle("id_after", 64'h0123456789ABCDEF, 32'h13579BDF);
    // inverting round function
    f_out = 32'hFFFFFFFF;
    start = 1;
    tick();
    start = 0;
    tick(17);
    chk("inv_r1", bo1, 64'hF1D3B597795B3D1F);
    chk("inv_r2", bo2, 64'hFEDCBA9876543210);
    chk("inv_r16", bo16, 64'h0123456789ABCDEF);
    chk("inv_ready", rdy16, 1);
    // three ack wait states in round 0
    f_ack = 0;
    start = 1;
    tick();
    start = 0;
    for (int w = 0; w < 3; w++) begin
      chk("wait_req", req16, 1);
      chk("wait_fd", fd16, 32'h13579BDF);
      chk("wait_rnd", rnd16, 0);
      chk("wait_r1", dn1, 0);
      tick();
    end
    f_ack = 1;
    for (int k = 0; k < 16; k++) begin
      chk("wait_nodone", dn16, 0);
      if (k == 1) chk("wait_r1_done", dn1, 1);
      tick();
    end
    chk("wait_done", dn16, 1);
    chk("wait_blk16", bo16, 64'h0123456789ABCDEF);
    chk("wait_blk1", bo1, 64'hF1D3B597795B3D1F);
    chk("wait_blk2", bo2, 64'hFEDCBA9876543210);
    tick();
    // abort at rnd=5 with a fresh block
    blk_in = 64'h1122334455667788;
    start = 1;
    tick();
    start = 0;
    tick(5);
    chk("ab_rnd5", rnd16, 5);
    abort = 1;
    tick();
    abort = 0;
    chk("ab_ready", {61'd0, rdy16, req16, dn16}, 64'h4);
    chk("ab_rnd", rnd16, 0);
    chk("ab_blk", bo16, 64'h0123456789ABCDEF);
    tick(12);
    chk("ab_nodone", {62'd0, dn16, rdy16}, 64'h1);
    chk("ab_blk_hold", bo16, 64'h0123456789ABCDEF);
    // asynchronous reset at rnd=7
    start = 1;
    tick();
    start = 0;
    tick(7);
    chk("rst_rnd7", rnd16, 7);
    #2 rst_n = 0;
    #1;
    chk_idle("rst_async", 64'h0, 32'h0);
    tick();
    rst_n = 1;
    tick(3);
    chk("ack_idle_fd", fd16, 32'h0);
    chk("ack_idle_rnd", rnd16, 0);
    // start together with abort stays idle
    start = 1;
    abort = 1;
    tick();
    abort = 0;
    chk_idle("st_ab", 64'h0, 32'h0);
    // full block after reset, start held high through REQ and DONE
    blk_in = 64'h0123456789ABCDEF;
    tick();
    for (int k = 0; k < 16; k++) begin
      chk("rob_rnd", rnd16, k);
      chk("rob_done", dn16, 0);
      tick();
    end
    chk("rob_done_hi", dn16, 1);
    chk("rob_blk", bo16, 64'h0123456789ABCDEF);
    tick();
    start = 0;
    chk("rob_ready", {62'd0, rdy16, dn16}, 64'h2);
    chk("rob_r2", bo2, 64'hFEDCBA9876543210);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/hb_round_ctrl.md
# hb_round_ctrl

Round sequencer for the HB cipher datapath. It captures a 64-bit block and iterates ROUNDS Feistel rounds over it. In each round it applies the parity-dependent nibble split (L/R halves), hands the R half to an external round function over a req/ack handshake, and writes the returned value XOR L back into the L nibble positions. It sits between the block I/O and the round-function unit and owns the round counter and state register.

## Interface
- ROUNDS, 16, number of rounds per block; legal range 1..255.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a block; sampled only when ready=1
- abort  in  1  synchronous cancel; returns to IDLE without done
- blk_in  in  [0:63]  plaintext block; captured on the accepted start edge
- ready  out  1  high in IDLE
- busy  out  1  high in REQ
- rnd  out  [0:7]  current round index
- f_req  out  1  round-function request
- f_data  out  [0:31]  R half for the current round; valid while f_req=1
- f_ack  in  1  round-function acknowledge; f_out valid in the same cycle
- f_out  in  [0:31]  round-function result
- done  out  1  one-cycle pulse; blk_out valid from this cycle
- blk_out  out  [0:63]  result block; held until the next accepted start

## Operation
- State register S[0:63].
- H(S) = {S[8i:8i+3]} for i=0..7, in ascending i.
- Lo(S) = {S[8i+4:8i+7]} for i=0..7, in ascending i.
- Round split:
  - rnd even: L=H(S), R=Lo(S).
  - rnd odd: L=Lo(S), R=H(S).
- f_data = R, driven combinationally from S and rnd[7].
- Update on ack: the nibbles of S at the L positions are replaced by L ^ f_out, mapped nibble-for-nibble in the same order. The R positions are unchanged.
- States: IDLE, REQ, DONE.
  - IDLE: ready=1. start=1 → S<=blk_in, rnd<=0, go to REQ.
  - REQ: f_req=1, busy=1. On f_ack=1:
    - apply the update;
    - if rnd==ROUNDS-1, blk_out<=updated S and go to DONE;
    - otherwise rnd<=rnd+1 and stay in REQ, with f_req held high and new f_data.
  - REQ with f_ack=0: hold; S, rnd and f_data are stable.
  - DONE: done=1 for exactly one cycle, then go to IDLE. rnd resets to 0 on DONE→IDLE.
- abort=1 in any state: next state is IDLE, rnd<=0, f_req drops, no done pulse, and blk_out is unchanged. abort has priority over f_ack and start in the same cycle.
- start is ignored outside IDLE. f_ack is ignored when f_req=0.
- rnd is 8 bits. The last round is detected by equality, so no wrap occurs.

## Timing
- Reset (asynchronous): state IDLE, ready=1, busy=0, f_req=0, done=0, rnd=0, S=0, blk_out=0.
- f_data=0 in IDLE, because it derives from S=0.
- Cycle 0 is the start edge. f_req is high from cycle 1.
- With a zero-wait ack, one round completes per cycle. The last ack lands on edge ROUNDS, done is high in cycle ROUNDS+1, and ready returns in cycle ROUNDS+2.
- Each cycle of f_ack low inside REQ adds exactly one cycle of latency.
- The next start is accepted no earlier than the first IDLE cycle after DONE. Back-to-back blocks therefore cost ROUNDS+2 cycles each.
- blk_out changes only on the final-ack edge.

## Test plan
- Identity round function, ROUNDS=16: f_out=0 with f_ack tied high, blk_in=0x0123456789ABCDEF. Required response:
  - blk_out=0x0123456789ABCDEF;
  - done high exactly in cycle 17 after the start edge, for one cycle;
  - rnd sequences 0..15.
- Split check: blk_in=0x0123456789ABCDEF. Required response:
  - round 0 f_data=0x13579BDF;
  - with f_out=0 on round 0, round 1 f_data=0x02468ACE.
- Inverting round function: f_out=0xFFFFFFFF, blk_in=0x0123456789ABCDEF.
  - ROUNDS=1 → blk_out=0xF1D3B597795B3D1F.
  - ROUNDS=2 → blk_out=0xFEDCBA9876543210.
- Ack wait states: f_ack low for 3 cycles in round 0, then tied high. Required response:
  - f_req and f_data held stable through the wait;
  - done delayed by exactly 3 cycles;
  - result unchanged versus the zero-wait run.
- Abort and reset mid-operation:
  - abort at rnd=5 → IDLE next cycle, no done, blk_out retains its previous value.
  - rst_n low at rnd=7 → all outputs take reset values immediately, before any clock edge.
  - A subsequent start runs a full block correctly.
- Protocol robustness:
  - start pulses in REQ and DONE are ignored.
  - f_ack pulses in IDLE do not modify S or rnd.
  - start asserted together with abort in IDLE → remains in IDLE.
